result_byte_serializer: RTL and testbench
=========================================

Name: result_byte_serializer

Overview:
- Output stage directly downstream of the matrix accumulate unit.
- Captures one 64-bit accumulated result word on a load strobe. Emits it as a sequence of 8-bit bytes over a valid/ready handshake toward the byte-wide output pins.
- Converts the wide accumulator result back to the 8-bit external data path, mirroring the byte-to-64-bit assembler on the input side.

Parameters:
- NBYTES, 8, number of bytes per result word; data_in width is 8*NBYTES.
- MSB_FIRST, 0, 0 = byte 0 (bits 7:0) sent first; 1 = most significant byte sent first.

Ports:
- clk  input  1  system clock, all logic on rising edge.
- rst  input  1  reset, asynchronous, active-high.
- data_in  input  8*NBYTES  accumulated result word from the accumulate unit.
- load  input  1  one-cycle strobe; capture data_in and start transmission.
- tx_ready  input  1  downstream can accept a byte this cycle.
- dato_out  output  8  current byte.
- tx_valid  output  1  dato_out holds a valid byte.
- busy  output  1  serializer holds an untransmitted word.
- done  output  1  one-cycle pulse after the final byte is accepted.

Behaviour:
- Reset (async, rst=1): state IDLE, shift register 0, byte counter 0. dato_out=8'h00, tx_valid=0, busy=0, done=0.
- FSM states:
  - IDLE: tx_valid=0, busy=0. load=1 captures data_in into the shift register, clears the counter, and moves to SEND. busy and tx_valid go high on the next cycle.
  - SEND: tx_valid=1, busy=1, dato_out = current byte.
    - Transfer occurs when tx_valid & tx_ready. On transfer the register advances one byte (shift right by 8 if MSB_FIRST=0, left by 8 if 1) and the counter increments.
    - Transfer of byte NBYTES-1 moves to DONE.
  - DONE: tx_valid=0, busy=0, done=1 for exactly one cycle, then IDLE.
- Latency: load in cycle N → first byte valid in cycle N+1. With tx_ready held high, byte k transfers in cycle N+1+k and done pulses in cycle N+1+NBYTES.
- Handshake rules:
  - While tx_valid=1 and tx_ready=0, dato_out and tx_valid hold stable; no byte is dropped or duplicated.
  - tx_valid never deasserts in SEND until the last transfer.
- load while busy=1, or in DONE, is ignored: the captured word is not altered and no queueing occurs. The upstream must wait for done.
- load in the same cycle as the last transfer is ignored.
- tx_ready while tx_valid=0 has no effect.
- Counter width is clog2(NBYTES+1), so it covers the optional extra byte without overflow.
- Reset asserted mid-transmission aborts immediately to IDLE with all outputs at reset values. No done pulse is generated.

Optional Feature:
- Macro: SER_CHECKSUM_EN.
- Defined:
  - A running XOR of all transmitted data bytes is kept, cleared on load.
  - After byte NBYTES-1 is accepted, SEND continues for one extra byte: dato_out = XOR of the NBYTES data bytes, under the same handshake.
  - DONE follows acceptance of this checksum byte, so total latency grows by one byte.
- Not defined: exactly NBYTES bytes are sent, and no checksum logic is present.

Test Plan:
- Default params, data_in=64'h0807060504030201, load at cycle 0, tx_ready=1: dato_out 01,02,…,08 transferred in cycles 1–8; done=1 only in cycle 9; busy=0 from cycle 9.
- MSB_FIRST=1, same data and stimulus: bytes 08,07,…,01 in order.
- tx_ready toggled 1,0,0,1,… during SEND: dato_out stable during stalls; exactly 8 transfers with the correct sequence; done after the 8th transfer.
- load asserted again with data_in=64'hFFFF_FFFF_FFFF_FFFF mid-transmission: ignored, original bytes complete. A load one cycle after done is accepted and FF bytes follow.
- rst pulsed after 3 bytes accepted: dato_out=00, tx_valid=0, busy=0 immediately and no done pulse. A subsequent load restarts from byte 0.
- SER_CHECKSUM_EN defined, data 64'h0807060504030201: 9th byte = 8'h08; done in cycle 10.

Source files
------------

// File: rtl/result_byte_serializer.sv
// result_byte_serializer: captures one wide result word on load and streams it out as bytes over valid/ready.
// Defining SER_CHECKSUM_EN appends one XOR checksum byte after the data bytes.
module result_byte_serializer #(
  parameter int NBYTES    = 8,
  parameter bit MSB_FIRST = 1'b0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [8*NBYTES-1:0]   data_in,
  input  logic                  load,
  input  logic                  tx_ready,
  output logic [7:0]            dato_out,
  output logic                  tx_valid,
  output logic                  busy,
  output logic                  done
);
  localparam int W  = 8 * NBYTES;
  localparam int CW = $clog2(NBYTES + 1);
`ifdef SER_CHECKSUM_EN
  localparam int NTX = NBYTES + 1;
`else
  localparam int NTX = NBYTES;
`endif
  typedef enum logic [1:0] {IDLE, SEND, DONE} state_t;
  state_t         state_q, state_d;
  logic [W-1:0]   sr_q, sr_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [7:0]     head, cur;
  logic           last;
  assign head = MSB_FIRST ? sr_q[W-1 -: 8] : sr_q[7:0];
  assign last = cnt_q == CW'(NTX - 1);
`ifdef SER_CHECKSUM_EN
  logic [7:0] csum_q, csum_d;
  // Once all data bytes have gone out, the counter selects the running XOR instead of the register.
  assign cur = (cnt_q == CW'(NBYTES)) ? csum_q : head;
  always_comb
    csum_d = (state_q == IDLE && load) ? 8'h00 :
             (state_q == SEND && tx_ready) ? csum_q ^ head : csum_q;
  always_ff @(posedge clk or posedge rst)
    if (rst) csum_q <= 8'h00;
    else     csum_q <= csum_d;
`else
  assign cur = head;
`endif
  always_comb begin
    state_d = state_q;
    sr_d    = sr_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: if (load) begin
        sr_d    = data_in;
        cnt_d   = '0;
        state_d = SEND;
      end
      SEND: if (tx_ready) begin
        sr_d    = MSB_FIRST ? {sr_q[W-9:0], 8'h00} : {8'h00, sr_q[W-1:8]};
        cnt_d   = cnt_q + CW'(1);
        state_d = last ? DONE : SEND;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state_q <= IDLE;
      sr_q    <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      sr_q    <= sr_d;
      cnt_q   <= cnt_d;
    end
  assign tx_valid = state_q == SEND;
  assign busy     = tx_valid;
  assign done     = state_q == DONE;
  assign dato_out = tx_valid ? cur : 8'h00;
endmodule

// File: tb/tb_result_byte_serializer.sv
// tb_result_byte_serializer: randomized and directed checks of both byte orders against a byte-list reference model.
module tb_result_byte_serializer;
  localparam int NB = 8;
`ifdef SER_CHECKSUM_EN
  localparam int NTX = NB + 1;
`else
  localparam int NTX = NB;
`endif
  logic clk = 1'b0, rst = 1'b1, load = 1'b0, tx_ready = 1'b0;
  logic [8*NB-1:0] data_in = '0;
  logic [7:0] dl, dm;
  logic vl, vm, bl, bm, dnl, dnm;
  int vec = 0, errs = 0;

  always #5 clk = ~clk;

  result_byte_serializer #(.NBYTES(NB), .MSB_FIRST(1'b0)) u_lsb (
    .clk(clk), .rst(rst), .data_in(data_in), .load(load), .tx_ready(tx_ready),
    .dato_out(dl), .tx_valid(vl), .busy(bl), .done(dnl));
  result_byte_serializer #(.NBYTES(NB), .MSB_FIRST(1'b1)) u_msb (
    .clk(clk), .rst(rst), .data_in(data_in), .load(load), .tx_ready(tx_ready),
    .dato_out(dm), .tx_valid(vm), .busy(bm), .done(dnm));

  // k-th byte on the wire: data bytes in the chosen order, then the XOR of all data bytes.
  function automatic logic [7:0] exp_byte(input logic [8*NB-1:0] d, input int k, input bit msb);
    logic [7:0] x = 8'h00;
    if (k >= NB) begin
      for (int i = 0; i < NB; i++) x ^= d[8*i +: 8];
      return x;
    end
    return msb ? d[8*(NB-1-k) +: 8] : d[8*k +: 8];
  endfunction

  task automatic test_reset;
    rst = 1'b1;
    @(negedge clk);
    vec++;
    if ({dl, vl, bl, dnl, dm, vm, bm, dnm} !== 22'b0) begin
      errs++;
      $display("FAIL reset_state: got %h/%b%b%b %h/%b%b%b want 00/000", dl, vl, bl, dnl, dm, vm, bm, dnm);
    end
    rst = 1'b0;
    tx_ready = 1'b1;
    @(negedge clk);
    vec++;
    if ({vl, bl, dnl} !== 3'b000) begin
      errs++;
      $display("FAIL idle_ready_no_effect: got valid/busy/done %b%b%b want 000", vl, bl, dnl);
    end
  endtask

  // mode 0: random tx_ready, 1: repeating 1,0,0,1 pattern, 2: tx_ready held high.
  task automatic test_stream(input logic [8*NB-1:0] d, input int mode, input bit noise);
    int k = 0, cyc = 0;
    bit r;
    data_in = d;
    load = 1'b1;
    tx_ready = 1'($urandom);
    @(negedge clk);
    load = 1'b0;
    while (k < NTX && cyc < 200) begin
      vec++;
      if ({vl, bl, dnl, vm} !== 4'b1101) begin
        errs++;
        $display("FAIL send_ctrl byte %0d: got valid/busy/done/valid_m %b%b%b%b want 1101", k, vl, bl, dnl, vm);
      end
      vec++;
      if (dl !== exp_byte(d, k, 1'b0) || dm !== exp_byte(d, k, 1'b1)) begin
        errs++;
        $display("FAIL byte %0d: got lsb %h msb %h want lsb %h msb %h", k, dl, dm,
                 exp_byte(d, k, 1'b0), exp_byte(d, k, 1'b1));
      end
      r = mode == 0 ? 1'($urandom_range(0, 1)) : mode == 1 ? (cyc % 4 == 0 || cyc % 4 == 3) : 1'b1;
      tx_ready = r;
      load = noise && ($urandom_range(0, 2) == 0);
      data_in = {$urandom, $urandom};
      if (r) k++;
      @(negedge clk);
      cyc++;
    end
    vec++;
    if (k < NTX) begin
      errs++;
      $display("FAIL timeout: got %0d bytes want %0d", k, NTX);
    end
    if (mode == 2) begin
      vec++;
      if (cyc !== NTX) begin
        errs++;
        $display("FAIL latency: got %0d cycles want %0d", cyc, NTX);
      end
    end
    vec++;
    if ({vl, bl, dnl, dnm} !== 4'b0011) begin
      errs++;
      $display("FAIL done_pulse: got valid/busy/done/done_m %b%b%b%b want 0011", vl, bl, dnl, dnm);
    end
    load = noise;
    data_in = {$urandom, $urandom};
    tx_ready = 1'($urandom);
    @(negedge clk);
    load = 1'b0;
    vec++;
    if ({vl, bl, dnl} !== 3'b000) begin
      errs++;
      $display("FAIL after_done: got valid/busy/done %b%b%b want 000", vl, bl, dnl);
    end
  endtask

  task automatic test_back_to_back;
    test_stream(64'h1122_3344_5566_7788, 1, 1'b1);
    test_stream(64'hFFFF_FFFF_FFFF_FFFF, 2, 1'b0);
  endtask

  task automatic test_reset_mid;
    logic [8*NB-1:0] d = {$urandom, $urandom};
    data_in = d;
    load = 1'b1;
    tx_ready = 1'b1;
    @(negedge clk);
    load = 1'b0;
    repeat (3) @(negedge clk);
    vec++;
    if (dl !== exp_byte(d, 3, 1'b0)) begin
      errs++;
      $display("FAIL pre_abort_byte: got %h want %h", dl, exp_byte(d, 3, 1'b0));
    end
    #2 rst = 1'b1;
    #1;
    vec++;
    if ({dl, vl, bl, dnl} !== 11'b0) begin
      errs++;
      $display("FAIL async_abort: got %h/%b%b%b want 00/000", dl, vl, bl, dnl);
    end
    @(negedge clk);
    rst = 1'b0;
    repeat (3) begin
      @(negedge clk);
      vec++;
      if ({vl, bl, dnl, dnm} !== 4'b0000) begin
        errs++;
        $display("FAIL no_done_after_abort: got valid/busy/done/done_m %b%b%b%b want 0000", vl, bl, dnl, dnm);
      end
    end
    test_stream({$urandom, $urandom}, 0, 1'b0);
  endtask

  initial begin
    test_reset;
    test_stream(64'h0807_0605_0403_0201, 2, 1'b0);
    test_stream(64'h0807_0605_0403_0201, 1, 1'b0);
    test_stream(64'hDEAD_BEEF_0123_4567, 1, 1'b1);
    test_back_to_back;
    for (int i = 0; i < 8; i++) test_stream({$urandom, $urandom}, 0, 1'b1);
    test_reset_mid;
    $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
    $finish;
  end
endmodule
